// File: rtl/wide_add_pkg.sv
// Shared definitions for the wide adder sequencer: FSM state encoding.
package wide_add_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/carry_skip_adder.sv
// N-bit carry-skip adder. Bits ripple inside each BLOCK_SIZE block; a block
// whose bits all propagate passes its incoming carry straight to the next
// block through the skip mux. The final block may be narrower than BLOCK_SIZE.
module carry_skip_adder #(
  parameter int BLOCK_SIZE = 2,
  parameter int N          = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  // Ripple within each block, skip across blocks that fully propagate.
  always_comb begin : p_add
    logic blk_cin;
    logic rip_c;
    logic blk_p;
    logic pr;
    sum     = '0;
    blk_cin = cin;
    rip_c   = cin;
    blk_p   = 1'b1;
    pr      = 1'b0;
    for (int k = 0; k < N; k++) begin
      if ((k % BLOCK_SIZE) == 0) begin
        rip_c = blk_cin;
        blk_p = 1'b1;
      end
      pr     = a[k] ^ b[k];
      sum[k] = pr ^ rip_c;
      rip_c  = (a[k] & b[k]) | (pr & rip_c);
      blk_p  = blk_p & pr;
      if (((k % BLOCK_SIZE) == (BLOCK_SIZE - 1)) || (k == (N - 1))) begin
        blk_cin = blk_p ? blk_cin : rip_c;
      end
    end
    cout = blk_cin;
  end

endmodule

// File: rtl/wide_add_sequencer.sv
// Adds two W = N*CHUNKS bit operands one N-bit chunk per cycle through a
// single shared carry-skip adder, carrying between chunks in a register.
//
// Handshake: an input transfer happens on a rising edge where
// in_valid && in_ready; an output transfer happens on a rising edge where
// out_valid && out_ready. in_ready is high only in IDLE and out_valid only
// in DONE, so a result must be taken before the next request is accepted.
// sum/cout hold steady while out_valid is high and out_ready is low.
module wide_add_sequencer
  import wide_add_pkg::*;
#(
  parameter int N          = 8,
  parameter int BLOCK_SIZE = 2,
  parameter int CHUNKS     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N*CHUNKS-1:0]   a,
  input  logic [N*CHUNKS-1:0]   b,
  input  logic                  cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N*CHUNKS-1:0]   sum,
  output logic                  cout,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  localparam int IW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(CHUNKS - 1);

  state_t                   state;
  logic [IW-1:0]            idx;
  logic [IW-1:0]            idx_inc;
  logic                     carry_q;
  logic                     cout_q;
  logic [CHUNKS-1:0][N-1:0] a_q;
  logic [CHUNKS-1:0][N-1:0] b_q;
  logic [CHUNKS-1:0][N-1:0] sum_q;
  logic [N-1:0]             add_sum;
  logic                     add_cout;

  // The one arithmetic unit: adds the current chunk pair plus running carry.
  carry_skip_adder #(
    .BLOCK_SIZE (BLOCK_SIZE),
    .N          (N)
  ) u_adder (
    .a    (a_q[idx]),
    .b    (b_q[idx]),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Next chunk index as a bitwise increment so the adder stays the only adder.
  always_comb begin : p_idx_inc
    logic c;
    idx_inc = '0;
    c       = 1'b1;
    for (int i = 0; i < IW; i++) begin
      idx_inc[i] = idx[i] ^ c;
      c          = c & idx[i];
    end
  end

  // FSM plus datapath registers: latch on accept, one chunk per RUN edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx     <= '0;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum_q[idx] <= add_sum;
          carry_q    <= add_cout;
          if (idx == LAST_IDX) begin
            cout_q <= add_cout;
            state  <= ST_DONE;
          end else begin
            idx <= idx_inc;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Status and result outputs decoded from registered state only.
  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
    busy      = (state != ST_IDLE);
    dbg_state = state;
    sum       = sum_q;
    cout      = cout_q;
  end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed bench for wide_add_sequencer: a 4-chunk instance driven from a
// vector table plus hand sequences for stall, reset and back-to-back, and a
// 1-chunk instance for the single-RUN-cycle case.
module tb_wide_add_sequencer;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
  logic [31:0] a, b, sum;
  logic [1:0]  dbg_state;

  logic        in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1, busy1;
  logic [7:0]  a1, b1, sum1;
  logic [1:0]  dbg_state1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
  } vec_t;

  vec_t vecs[10];

  logic [32:0] exp_q[$];
  int          acc_cyc[$];

  wide_add_sequencer #(.N(8), .BLOCK_SIZE(2), .CHUNKS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy), .dbg_state(dbg_state)
  );

  wide_add_sequencer #(.N(8), .BLOCK_SIZE(2), .CHUNKS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .busy(busy1), .dbg_state(dbg_state1)
  );

  // Clock and global watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Driver helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("wait_in_ready", in_ready, 1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    wait_ready();
    in_valid = 1'b1;
    a = v.a;
    b = v.b;
    cin = v.cin;
    tick();
    in_valid = 1'b0;
    a = $urandom();
    b = $urandom();
    cin = 1'($urandom_range(0, 1));
    check({tag, "_state_run"}, dbg_state, 2'd1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, 4);
    check({tag, "_sum"}, sum, v.sum);
    check({tag, "_cout"}, cout, v.cout);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_ready_after"}, in_ready, 1);
  endtask

  // Main test sequence
  initial begin
    int  lat;
    int  k;
    int  results;
    bit  acc;
    bit  seen;
    logic [32:0] got;
    logic [32:0] want;

    vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1};
    vecs[2] = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0};
    vecs[3] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
    vecs[4] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
    vecs[5] = '{32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0};
    vecs[6] = '{32'h7FFFFFFF, 32'h00000000, 1'b1, 32'h80000000, 1'b0};
    vecs[7] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, 32'h00000000, 1'b1};
    vecs[8] = '{32'hDEADBEEF, 32'h01234567, 1'b0, 32'hDFD10456, 1'b0};
    vecs[9] = '{32'hFFFF0000, 32'h0000FFFF, 1'b1, 32'h00000000, 1'b1};

    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;

    // Reset state, sampled while reset is held
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_state", dbg_state, 2'd0);
    check("rst_in_ready1", in_ready1, 1);
    rst = 1'b0;
    tick();

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Output stall: result and carry must not move, no new request accepted
    wait_ready();
    in_valid = 1'b1; a = 32'h12345678; b = 32'h11111111; cin = 1'b0;
    tick();
    lat = 0;
    while (!out_valid && lat < 20) begin
      in_valid = 1'b1;
      a = $urandom();
      b = $urandom();
      tick();
      lat++;
    end
    check("stall_latency", lat, 4);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      a = $urandom();
      b = $urandom();
      check($sformatf("stall_valid_%0d", c), out_valid, 1);
      check($sformatf("stall_sum_%0d", c), sum, 32'h23456789);
      check($sformatf("stall_cout_%0d", c), cout, 0);
      check($sformatf("stall_in_ready_%0d", c), in_ready, 0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("stall_release_idle", in_ready, 1);

    // Asynchronous reset during the second RUN cycle
    in_valid = 1'b1; a = 32'h12345678; b = 32'h11111111; cin = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    check("midrun_chunk0", sum[7:0], 8'h89);
    check("midrun_state", dbg_state, 2'd1);
    #2;
    rst = 1'b1;
    #1;
    check("midrun_rst_state", dbg_state, 2'd0);
    check("midrun_rst_in_ready", in_ready, 1);
    check("midrun_rst_busy", busy, 0);
    check("midrun_rst_sum", sum, 0);
    check("midrun_rst_out_valid", out_valid, 0);
    #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("midrun_no_out_valid", seen, 0);

    // Back-to-back requests with in_valid held high and out_ready high
    k = 0;
    results = 0;
    in_valid = 1'b1; a = vecs[0].a; b = vecs[0].b; cin = vecs[0].cin;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && results < 3; cyc++) begin
      acc = 1'b0;
      if (in_ready && in_valid) begin
        exp_q.push_back({vecs[k].cout, vecs[k].sum});
        acc_cyc.push_back(cyc);
        k++;
        acc = 1'b1;
      end
      if (out_valid) begin
        got = {cout, sum};
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h0;
        check($sformatf("b2b_result_%0d", results), got, want);
        results++;
      end
      tick();
      if (acc) begin
        if (k < 3) begin
          a = vecs[k].a; b = vecs[k].b; cin = vecs[k].cin;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("b2b_results", results, 3);
    if (acc_cyc.size() == 3) begin
      check("b2b_interval_0", acc_cyc[1] - acc_cyc[0], 6);
      check("b2b_interval_1", acc_cyc[2] - acc_cyc[1], 6);
    end else begin
      check("b2b_accepts", acc_cyc.size(), 3);
    end

    // Single-chunk instance: one RUN cycle, carry straight to cout
    in_valid1 = 1'b1; a1 = 8'hFF; b1 = 8'hFF; cin1 = 1'b1;
    tick();
    in_valid1 = 1'b0; a1 = 8'h00; b1 = 8'h00; cin1 = 1'b0;
    check("c1_state_run", dbg_state1, 2'd1);
    lat = 0;
    while (!out_valid1 && lat < 10) begin
      tick();
      lat++;
    end
    check("c1_latency", lat, 1);
    check("c1_sum", sum1, 8'hFF);
    check("c1_cout", cout1, 1);
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
    check("c1_ready_after", in_ready1, 1);

    in_valid1 = 1'b1; a1 = 8'h01; b1 = 8'h02; cin1 = 1'b0;
    tick();
    in_valid1 = 1'b0;
    lat = 0;
    while (!out_valid1 && lat < 10) begin
      tick();
      lat++;
    end
    check("c1b_latency", lat, 1);
    check("c1b_sum", sum1, 8'h03);
    check("c1b_cout", cout1, 0);
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
